// File: rtl/pipelined_multiplier_pkg.sv
// Shared types and sizing helpers for the multiplier result path.
// Default configuration: 16-bit operands, 4-deep multiplier, 8-entry result queue.
package pipelined_multiplier_pkg;

    localparam int PKG_DATA_WIDTH     = 16;
    localparam int PKG_PIPELINE_DEPTH = 4;
    localparam int PKG_FIFO_DEPTH     = 8;
    localparam int MUL_LATENCY        = PKG_PIPELINE_DEPTH - 1;

    typedef logic [2*PKG_DATA_WIDTH-1:0] product_t;

    // Width needed to hold a count from 0 to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/result_sync_fifo.sv
// Synchronous FWFT result store; head visible the cycle after the push edge.
// Push into a full queue is dropped unless a pop frees the slot in the same cycle; pop on empty is ignored.
module result_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_multiplier_result_queue.sv
// Credit-managed result queue behind a non-stallable multiplier, with per-op sign correction.
// Push-to-visible 1 cycle (issue-to-visible PIPELINE_DEPTH); credits withheld once every slot is reserved.
module pipelined_multiplier_result_queue
    import pipelined_multiplier_pkg::*;
#(
    parameter int DATA_WIDTH     = PKG_DATA_WIDTH,
    parameter int PIPELINE_DEPTH = PKG_PIPELINE_DEPTH,
    parameter int FIFO_DEPTH     = PKG_FIFO_DEPTH
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            clk_en_i,
    input  logic                            issue_valid_i,
    input  logic                            issue_negate_i,
    output logic                            issue_ready_o,
    input  logic [2*DATA_WIDTH-1:0]         product_i,
    input  logic                            product_valid_i,
    output logic [2*DATA_WIDTH-1:0]         result_o,
    output logic                            result_valid_o,
    input  logic                            result_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] in_flight_o,
    output logic                            overflow_o
);

    localparam int PW      = 2 * DATA_WIDTH;
    localparam int TAG_LEN = PIPELINE_DEPTH - 1;
    localparam int CNT_W   = count_width(FIFO_DEPTH);

    logic               ready_en;
    logic               accept;
    logic               push_req;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               tag_out;
    logic [TAG_LEN-1:0] tag_line;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   in_flight;
    logic [CNT_W:0]     credit_used;
    logic [PW-1:0]      push_dat;

    assign credit_used    = {1'b0, fifo_count} + {1'b0, in_flight};
    assign issue_ready_o  = ready_en && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign accept         = issue_valid_i && issue_ready_o && clk_en_i;
    assign push_req       = product_valid_i && clk_en_i;
    assign result_valid_o = !fifo_empty;
    assign pop            = result_valid_o && result_ready_i;
    assign tag_out        = tag_line[TAG_LEN-1];
    assign push_dat       = tag_out ? (~product_i + PW'(1)) : product_i;
    assign fifo_count_o   = fifo_count;
    assign in_flight_o    = in_flight;

    // Holds credits off for the first cycle after reset release.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    // Saturate at zero so a stray push (upstream ignoring credits) cannot wrap the count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_flight <= '0;
        end else begin
            case ({accept, push_req && (in_flight != '0)})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Negate flag travels in lockstep with the multiplier's valid bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tag_line <= '0;
        end else if (clk_en_i) begin
            tag_line[0] <= accept && issue_negate_i;
            for (int i = 1; i < TAG_LEN; i++) begin
                tag_line[i] <= tag_line[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_o <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow_o <= 1'b1;
        end
    end

    result_sync_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .push     (push_req),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (result_o),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule
